// File: rtl/decryption_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decryption_pkg: shared FSM states, op codes and regfile addresses  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package decryption_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_KEY_LO = 8'h10;
  localparam logic [7:0] ADDR_KEY_HI = 8'h12;
  localparam logic [7:0] ADDR_STATUS = 8'h14;

endpackage : decryption_pkg
`default_nettype wire

// File: rtl/decryption_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decryption_rr_pick: 2-way round-robin picker, one-hot result       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module decryption_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  // On contention the port that did not win last time takes the grant.
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule : decryption_rr_pick
`default_nettype wire

// File: rtl/decryption_reg_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decryption_reg_arbiter: round-robin share of the regfile port      |
// | between host bridge (0) and key-loader (1), with done watchdog.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module decryption_reg_arbiter
  import decryption_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [REG_WIDTH-1:0]  m0_wdata,
  output logic [REG_WIDTH-1:0]  m0_rdata,
  output logic                  m0_done,
  output logic                  m0_error,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [REG_WIDTH-1:0]  m1_wdata,
  output logic [REG_WIDTH-1:0]  m1_rdata,
  output logic                  m1_done,
  output logic                  m1_error,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_read,
  output logic                  s_write,
  output logic [REG_WIDTH-1:0]  s_wdata,
  input  logic [REG_WIDTH-1:0]  s_rdata,
  input  logic                  s_done,
  input  logic                  s_error,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic [1:0]            r_grant;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic                  r_op;
  logic [CNT_W-1:0]      r_cnt;

  logic [1:0]            w_req;
  logic [1:0]            w_pick;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [REG_WIDTH-1:0]  w_wdata;
  logic                  w_op;
  logic                  w_resp_now;
  logic [REG_WIDTH-1:0]  w_resp_rdata;
  logic                  w_resp_error;

  assign w_req   = {m1_read | m1_write, m0_read | m0_write};
  assign w_addr  = w_pick[1] ? m1_addr  : m0_addr;
  assign w_wdata = w_pick[1] ? m1_wdata : m0_wdata;
  assign w_op    = w_pick[1] ? m1_write : m0_write;

  decryption_rr_pick u_pick (
    .req        (w_req),
    .last_grant (r_last_grant),
    .pick       (w_pick)
  );

  // A missing done after the last WAIT cycle becomes an error with zero data.
  assign w_resp_now   = s_done || (r_cnt == CNT_LAST);
  assign w_resp_rdata = s_done ? s_rdata : '0;
  assign w_resp_error = s_done ? s_error : 1'b1;

  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
  assign grant   = r_grant;
  assign busy    = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_op         <= OP_READ;
      r_cnt        <= '0;
      s_read       <= 1'b0;
      s_write      <= 1'b0;
      m0_done      <= 1'b0;
      m0_error     <= 1'b0;
      m0_rdata     <= '0;
      m1_done      <= 1'b0;
      m1_error     <= 1'b0;
      m1_rdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_pick) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick[1];
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_op         <= w_op;
            s_write      <= (w_op == OP_WRITE);
            s_read       <= (w_op == OP_READ);
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          s_read  <= 1'b0;
          s_write <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_resp_now) begin
            m0_done  <= r_grant[0];
            m0_error <= r_grant[0] & w_resp_error;
            m0_rdata <= r_grant[0] ? w_resp_rdata : '0;
            m1_done  <= r_grant[1];
            m1_error <= r_grant[1] & w_resp_error;
            m1_rdata <= r_grant[1] ? w_resp_rdata : '0;
            r_state  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          m0_done  <= 1'b0;
          m0_error <= 1'b0;
          m0_rdata <= '0;
          m1_done  <= 1'b0;
          m1_error <= 1'b0;
          m1_rdata <= '0;
          r_grant  <= 2'b00;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : decryption_reg_arbiter
`default_nettype wire

// File: doc/decryption_reg_arbiter.md
Name: decryption_reg_arbiter

Overview:
- Shares the single register-access port of the decryption register file between two requesters: port 0, the host bus bridge, and port 1, the key-loader/sequencer.
- Arbitrates round-robin and issues exactly one single-cycle read or write strobe per transaction.
- Waits for the register file's registered done/error, then returns the response to the granted requester only.
- A watchdog converts a missing done into an error response, so no requester can hang the port.

Parameters:
addr_width, 8, width of register address
reg_width, 16, width of register data
timeout_cycles, 8, maximum WAIT cycles before forced error (must be >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
m0_addr  input  addr_width  requester 0 register address
m0_read  input  1  requester 0 read request (level, held until m0_done)
m0_write  input  1  requester 0 write request (level, held until m0_done)
m0_wdata  input  reg_width  requester 0 write data
m0_rdata  output  reg_width  requester 0 read data, valid when m0_done=1
m0_done  output  1  requester 0 one-cycle completion pulse
m0_error  output  1  requester 0 error flag, valid when m0_done=1
m1_addr, m1_read, m1_write, m1_wdata, m1_rdata, m1_done, m1_error  same as m0_*, for requester 1
s_addr  output  addr_width  to regfile addr
s_read  output  1  to regfile read strobe
s_write  output  1  to regfile write strobe
s_wdata  output  reg_width  to regfile wdata
s_rdata  input  reg_width  from regfile rdata
s_done  input  1  from regfile done
s_error  input  1  from regfile error
grant  output  2  one-hot owner of current transaction, 00 when idle
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0.
  - Latched addr/wdata/op registers are 0.
  - last_grant=1, so requester 0 wins the first contention.
  - The watchdog counter is 0.
- Request definition: req_i = mi_read | mi_write. If both are set, the operation is a write.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both req: grant the requester != last_grant.
  - On grant, latch addr, wdata and op, set grant one-hot and update last_grant, then go to ISSUE.
- ISSUE (1 cycle):
  - Drive s_addr/s_wdata from the latches.
  - Drive s_write=1 or s_read=1 (exactly one).
  - Clear the counter and go to WAIT.
- WAIT:
  - s_read and s_write are 0; s_addr and s_wdata are held.
  - s_done=1: capture s_rdata and s_error and go to RESP.
  - s_done=0 with counter == timeout_cycles-1: capture rdata=0, error=1 and go to RESP.
  - Otherwise increment the counter.
- RESP (1 cycle):
  - The granted requester sees mi_done=1 with the captured mi_rdata and mi_error.
  - The non-granted requester's done, error and rdata stay 0.
  - Go to IDLE and clear grant.
- Response outputs are 0 in every cycle other than RESP. rdata is forwarded for writes too, and requesters ignore it.
- Latency, no contention: request seen in IDLE at cycle 0, ISSUE at 1, WAIT at 2 (regfile done is registered), RESP with mi_done at 3. A new transaction can start in the cycle after RESP, giving 4 cycles per access back-to-back.
- Requester rule: deassert, or change to the next request, on the edge where mi_done=1 is sampled. Because of the IDLE cycle, a held request from the just-served port is never reissued ahead of a pending port.
- Requester changes addr/wdata/op after grant: ignored, the latched values are used.
- Requester drops its request mid-transaction: the transaction still completes and the done pulse is still issued.
- s_done=1 seen in IDLE or ISSUE (stale): ignored.
- Reset asserted mid-transaction: immediate return to the reset state. No done is issued, and the regfile write may or may not have taken effect.
- Address decode and error generation belong to the regfile. The arbiter never checks addresses.

Decomposition:
- Shared package decryption_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3;
  - OP_READ=1'b0, OP_WRITE=1'b1;
  - regfile address constants 'h00, 'h10, 'h12, 'h14, reused by the benches.
- One natural sub-module, decryption_rr_pick: a combinational 2-way round-robin picker. Inputs are req[1:0] and last_grant; output is a one-hot pick. FSM, latches and watchdog stay in the top level.

Test Plan:
- Write, requester 0 alone: m0_write=1, addr 'h10, wdata 'h0003.
  - s_write=1 for exactly 1 cycle at cycle 1 with s_addr='h10 and s_wdata='h0003.
  - m0_done=1 and m0_error=0 at cycle 3.
  - m1_done stays 0.
- Contention from reset: m0 and m1 both read 'h12 from cycle 0 and re-request immediately after each done.
  - Grants go m0, m1, m0, m1.
  - Each read returns 'hFFFF, the regfile reset value.
  - Done pulses are 4 cycles apart.
- Invalid address: m1 reads 'h20 → m1_done=1, m1_error=1, m1_rdata=0.
- Read and write together: m0_read=1 and m0_write=1 at addr 'h00 → only s_write pulses.
- Timeout: s_done forced 0 with timeout_cycles=8.
  - RESP follows the 8th WAIT cycle, so m0_done is at cycle 10.
  - m0_error=1, m0_rdata=0.
  - The arbiter returns to IDLE and serves the next request normally.
- Reset during WAIT: rst_n=0 asynchronously.
  - busy and grant go 0 immediately.
  - No done pulse is issued.
  - After release, m0 wins a simultaneous request.
